// File: rtl/orion_types.sv
// Shared pipeline types for the Orion core: datapath widths and the
// execute->fetch redirect and fetch->decode handoff structures.
package orion_types;

  localparam int XLEN  = 32;
  localparam int ADDRW = 32;
  localparam int DATAW = 32;

  typedef struct packed {
    logic            jump_en;
    logic [XLEN-1:0] jump_addr;
  } ex_if_t;

  typedef struct packed {
    logic [XLEN-1:0]  pc;
    logic [DATAW-1:0] instr;
    logic             valid;
  } if_id_t;

endpackage

// File: rtl/ifq_fifo.sv
// Instruction queue between the I$ response path and decode. Pointers carry
// an extra wrap bit so full and empty are distinguishable without a counter.
module ifq_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [PW:0]      count_o
);

  logic [PW:0]      wr_ptr;
  logic [PW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_i) wr_ptr <= wr_ptr + (PW+1)'(1);
      if (pop_i)  rd_ptr <= rd_ptr + (PW+1)'(1);
    end
  end

  // Storage needs no reset; the pointers alone define which entries are live.
  always_ff @(posedge clk_i) begin
    if (push_i && !flush_i) mem[wr_ptr[PW-1:0]] <= wdata_i;
  end

  assign rdata_o = mem[rd_ptr[PW-1:0]];
  assign count_o = wr_ptr - rd_ptr;
  assign empty_o = (wr_ptr == rd_ptr);
  assign full_o  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);

endmodule

// File: rtl/prefetch_unit.sv
// Instruction prefetcher: issues sequential word fetches to the I$ under a
// credit scheme, queues responses for decode and handles redirects.
module prefetch_unit
  import orion_types::*;
#(
  parameter logic [ADDRW-1:0] PC_RESET_ADDR   = 32'h8000_0000,
  parameter int               FIFO_DEPTH      = 4,
  parameter int               MAX_OUTSTANDING = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  output logic [ADDRW-1:0] imem_addr_o,
  output logic             imem_valid_o,
  input  logic             imem_ready_i,
  input  logic [DATAW-1:0] imem_rdata_i,
  input  logic             imem_resp_i,
  input  logic             stall_i,
  input  ex_if_t           ex_if_i,
  output if_id_t           if_id_o
);

  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam int PW = $clog2(FIFO_DEPTH);

  logic [XLEN-1:0]       req_pc;
  logic [XLEN-1:0]       resp_pc;
  logic [CW-1:0]         outstanding;
  logic [CW-1:0]         discard_cnt;
  logic [CW-1:0]         live;
  logic [CW-1:0]         after_resp;
  logic [PW:0]           fifo_count;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [XLEN+DATAW-1:0] fifo_rdata;
  logic [31:0]           pending_slots;
  logic [XLEN-1:0]       jump_target;
  logic                  jump;
  logic                  resp_ok;
  logic                  transfer;
  logic                  push;
  logic                  pop;
  logic                  drop;
  logic                  unused_bits;

  assign jump        = ex_if_i.jump_en;
  assign jump_target = {ex_if_i.jump_addr[XLEN-1:2], 2'b00};
  assign unused_bits = ^{ex_if_i.jump_addr[1:0], req_pc[1:0]};

  // Responses belonging to flushed requests still occupy the I$, but they
  // will never reach the queue, so only "live" requests consume queue credit.
  assign live          = outstanding - discard_cnt;
  assign pending_slots = 32'(fifo_count) + 32'(live);
  assign resp_ok       = imem_resp_i && (outstanding != '0);
  assign after_resp    = outstanding - CW'(resp_ok);

  assign imem_valid_o = !rst_i && !jump && (live < CW'(MAX_OUTSTANDING)) &&
                        (pending_slots < 32'(FIFO_DEPTH));
  assign imem_addr_o  = {req_pc[XLEN-1:2], 2'b00};

  assign transfer = imem_valid_o && imem_ready_i;
  assign drop     = resp_ok && (discard_cnt != '0);
  assign push     = resp_ok && (discard_cnt == '0) && !jump && (!fifo_full || pop);
  assign pop      = if_id_o.valid && !stall_i;

  assign if_id_o = '{pc:    fifo_rdata[XLEN+DATAW-1:DATAW],
                     instr: fifo_rdata[DATAW-1:0],
                     valid: !fifo_empty && !jump};

  // A redirect marks everything still in flight (minus a response landing
  // this very cycle, which is dropped here) as stale.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      req_pc      <= PC_RESET_ADDR;
      resp_pc     <= PC_RESET_ADDR;
      outstanding <= '0;
      discard_cnt <= '0;
    end else if (jump) begin
      req_pc      <= jump_target;
      resp_pc     <= jump_target;
      outstanding <= after_resp;
      discard_cnt <= after_resp;
    end else begin
      if (transfer) req_pc <= req_pc + XLEN'(4);
      if (push)     resp_pc <= resp_pc + XLEN'(4);
      if (transfer && !resp_ok)      outstanding <= outstanding + CW'(1);
      else if (!transfer && resp_ok) outstanding <= outstanding - CW'(1);
      if (drop) discard_cnt <= discard_cnt - CW'(1);
    end
  end

  ifq_fifo #(
    .WIDTH (XLEN + DATAW),
    .DEPTH (FIFO_DEPTH)
  ) u_ifq (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (jump),
    .push_i  (push),
    .wdata_i ({resp_pc, imem_rdata_i}),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

endmodule

// File: tb/tb_prefetch_unit.sv
// Directed bench for prefetch_unit: an in-order I$ responder plus a decode
// monitor, with one task per scenario and hand-derived expected values.
module tb_prefetch_unit;
  import orion_types::*;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] imem_addr_o;
  logic        imem_valid_o;
  logic        imem_ready_i;
  logic [31:0] imem_rdata_i;
  logic        imem_resp_i;
  logic        stall_i;
  ex_if_t      ex_if_i;
  if_id_t      if_id_o;

  int          checks = 0;
  int          errors = 0;
  logic        resp_en;
  logic [31:0] pend[$];
  logic [31:0] got_pc[$];
  logic [31:0] got_instr[$];
  int          n_issued;

  prefetch_unit dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .imem_addr_o  (imem_addr_o),
    .imem_valid_o (imem_valid_o),
    .imem_ready_i (imem_ready_i),
    .imem_rdata_i (imem_rdata_i),
    .imem_resp_i  (imem_resp_i),
    .stall_i      (stall_i),
    .ex_if_i      (ex_if_i),
    .if_id_o      (if_id_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1234_5678;
  endfunction

  // I$ model: a request accepted in cycle N is answered in cycle N+1 when enabled.
  initial begin
    imem_resp_i  = 1'b0;
    imem_rdata_i = '0;
    forever begin
      @(negedge clk_i);
      if (!rst_i && imem_valid_o && imem_ready_i) begin
        pend.push_back(imem_addr_o);
        n_issued++;
      end
      @(posedge clk_i);
      #2;
      if (resp_en && pend.size() > 0) begin
        imem_resp_i  = 1'b1;
        imem_rdata_i = instr_of(pend.pop_front());
      end else begin
        imem_resp_i  = 1'b0;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk_i);
      if (if_id_o.valid && !stall_i) begin
        got_pc.push_back(if_id_o.pc);
        got_instr.push_back(if_id_o.instr);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    rst_i        = 1'b1;
    resp_en      = 1'b0;
    imem_ready_i = 1'b1;
    stall_i      = 1'b0;
    ex_if_i      = '0;
    repeat (2) step();
    pend.delete();
    got_pc.delete();
    got_instr.delete();
    n_issued = 0;
    rst_i    = 1'b0;
  endtask

  task automatic test_reset();
    rst_i        = 1'b1;
    resp_en      = 1'b0;
    imem_ready_i = 1'b1;
    stall_i      = 1'b0;
    ex_if_i      = '0;
    repeat (2) step();
    @(negedge clk_i);
    checks++;
    if (imem_valid_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_imem_valid: got %b expected 0", imem_valid_o);
    end
    checks++;
    if (if_id_o.valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_ifid_valid: got %b expected 0", if_id_o.valid);
    end
    checks++;
    if (imem_addr_o !== 32'h8000_0000) begin
      errors++;
      $display("[TB] FAIL reset_addr: got %h expected 80000000", imem_addr_o);
    end
  endtask

  task automatic test_stream();
    logic [31:0] exp_addr;
    logic [31:0] exp_pc;
    do_reset();
    resp_en = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk_i);
      exp_addr = 32'h8000_0000 + 32'(4 * k);
      checks++;
      if (imem_valid_o !== 1'b1 || imem_addr_o !== exp_addr) begin
        errors++;
        $display("[TB] FAIL stream_issue[%0d]: got valid=%b addr=%h expected valid=1 addr=%h",
                 k, imem_valid_o, imem_addr_o, exp_addr);
      end
      if (k >= 2) begin
        exp_pc = 32'h8000_0000 + 32'(4 * (k - 2));
        checks++;
        if (if_id_o.valid !== 1'b1 || if_id_o.pc !== exp_pc || if_id_o.instr !== instr_of(exp_pc)) begin
          errors++;
          $display("[TB] FAIL stream_decode[%0d]: got valid=%b pc=%h instr=%h expected valid=1 pc=%h instr=%h",
                   k, if_id_o.valid, if_id_o.pc, if_id_o.instr, exp_pc, instr_of(exp_pc));
        end
      end
      step();
    end
  endtask

  task automatic test_stall();
    int bad;
    do_reset();
    stall_i = 1'b1;
    resp_en = 1'b1;
    repeat (9) step();
    @(negedge clk_i);
    checks++;
    if (imem_valid_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL stall_valid_drop: got %b expected 0", imem_valid_o);
    end
    checks++;
    if (n_issued !== 4 || pend.size() !== 0) begin
      errors++;
      $display("[TB] FAIL stall_inflight: got issued=%0d pending=%0d expected issued=4 pending=0",
               n_issued, pend.size());
    end
    checks++;
    if (if_id_o.valid !== 1'b1 || if_id_o.pc !== 32'h8000_0000) begin
      errors++;
      $display("[TB] FAIL stall_head: got valid=%b pc=%h expected valid=1 pc=80000000",
               if_id_o.valid, if_id_o.pc);
    end
    step();
    stall_i = 1'b0;
    got_pc.delete();
    got_instr.delete();
    repeat (10) step();
    checks++;
    if (got_pc.size() !== 10) begin
      errors++;
      $display("[TB] FAIL stall_drain_count: got %0d expected 10", got_pc.size());
    end
    bad = 0;
    foreach (got_pc[i]) begin
      if (got_pc[i] !== 32'h8000_0000 + 32'(4 * i) || got_instr[i] !== instr_of(got_pc[i])) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("[TB] FAIL stall_drain_order: got %0d out-of-sequence entries expected 0", bad);
    end
  endtask

  task automatic test_jump();
    do_reset();
    step();
    step();
    @(negedge clk_i);
    checks++;
    if (imem_valid_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL jump_credit_cap: got valid=%b expected 0", imem_valid_o);
    end
    step();
    ex_if_i = '{jump_en: 1'b1, jump_addr: 32'h8000_0100};
    got_pc.delete();
    got_instr.delete();
    @(negedge clk_i);
    checks++;
    if (imem_valid_o !== 1'b0 || if_id_o.valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL jump_gating: got imem_valid=%b ifid_valid=%b expected 0 0",
               imem_valid_o, if_id_o.valid);
    end
    step();
    ex_if_i = '0;
    resp_en = 1'b1;
    @(negedge clk_i);
    checks++;
    if (imem_valid_o !== 1'b1 || imem_addr_o !== 32'h8000_0100) begin
      errors++;
      $display("[TB] FAIL jump_first_issue: got valid=%b addr=%h expected valid=1 addr=80000100",
               imem_valid_o, imem_addr_o);
    end
    repeat (6) step();
    checks++;
    if (got_pc.size() < 2 || got_pc[0] !== 32'h8000_0100 || got_instr[0] !== instr_of(32'h8000_0100)
        || got_pc[1] !== 32'h8000_0104) begin
      errors++;
      $display("[TB] FAIL jump_target_decode: got n=%0d pc0=%h instr0=%h pc1=%h expected pc0=80000100 instr0=%h pc1=80000104",
               got_pc.size(), (got_pc.size() > 0) ? got_pc[0] : 32'h0,
               (got_instr.size() > 0) ? got_instr[0] : 32'h0,
               (got_pc.size() > 1) ? got_pc[1] : 32'h0, instr_of(32'h8000_0100));
    end
  endtask

  task automatic test_jump_resp();
    do_reset();
    step();
    step();
    step();
    ex_if_i = '{jump_en: 1'b1, jump_addr: 32'h8000_0200};
    resp_en = 1'b1;
    got_pc.delete();
    got_instr.delete();
    step();
    ex_if_i = '0;
    @(negedge clk_i);
    checks++;
    if (dut.discard_cnt !== 2'd1) begin
      errors++;
      $display("[TB] FAIL jumpresp_discard: got %0d expected 1", dut.discard_cnt);
    end
    checks++;
    if (imem_valid_o !== 1'b1 || imem_addr_o !== 32'h8000_0200) begin
      errors++;
      $display("[TB] FAIL jumpresp_issue: got valid=%b addr=%h expected valid=1 addr=80000200",
               imem_valid_o, imem_addr_o);
    end
    repeat (5) step();
    checks++;
    if (got_pc.size() < 1 || got_pc[0] !== 32'h8000_0200 || got_instr[0] !== instr_of(32'h8000_0200)) begin
      errors++;
      $display("[TB] FAIL jumpresp_decode: got n=%0d pc0=%h instr0=%h expected pc0=80000200 instr0=%h",
               got_pc.size(), (got_pc.size() > 0) ? got_pc[0] : 32'h0,
               (got_instr.size() > 0) ? got_instr[0] : 32'h0, instr_of(32'h8000_0200));
    end
  endtask

  task automatic test_ready_low();
    do_reset();
    imem_ready_i = 1'b0;
    resp_en      = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk_i);
      checks++;
      if (imem_valid_o !== 1'b1 || imem_addr_o !== 32'h8000_0000) begin
        errors++;
        $display("[TB] FAIL ready_low_hold[%0d]: got valid=%b addr=%h expected valid=1 addr=80000000",
                 k, imem_valid_o, imem_addr_o);
      end
      step();
    end
    checks++;
    if (n_issued !== 0 || imem_resp_i !== 1'b0) begin
      errors++;
      $display("[TB] FAIL ready_low_transfer: got issued=%0d resp=%b expected 0 0", n_issued, imem_resp_i);
    end
    imem_ready_i = 1'b1;
    step();
    @(negedge clk_i);
    checks++;
    if (imem_valid_o !== 1'b1 || imem_addr_o !== 32'h8000_0004) begin
      errors++;
      $display("[TB] FAIL ready_low_advance: got valid=%b addr=%h expected valid=1 addr=80000004",
               imem_valid_o, imem_addr_o);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    stall_i = 1'b1;
    resp_en = 1'b1;
    step();
    step();
    resp_en = 1'b0;
    step();
    rst_i   = 1'b1;
    resp_en = 1'b1;
    #1;
    checks++;
    if (imem_valid_o !== 1'b0 || imem_addr_o !== 32'h8000_0000 || if_id_o.valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midreset_immediate: got valid=%b addr=%h ifid_valid=%b expected 0 80000000 0",
               imem_valid_o, imem_addr_o, if_id_o.valid);
    end
    step();
    step();
    @(negedge clk_i);
    checks++;
    if (imem_valid_o !== 1'b0 || if_id_o.valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midreset_held: got valid=%b ifid_valid=%b expected 0 0", imem_valid_o, if_id_o.valid);
    end
    step();
    resp_en = 1'b0;
    pend.delete();
    got_pc.delete();
    got_instr.delete();
    n_issued = 0;
    stall_i  = 1'b0;
    rst_i    = 1'b0;
    resp_en  = 1'b1;
    @(negedge clk_i);
    checks++;
    if (imem_valid_o !== 1'b1 || imem_addr_o !== 32'h8000_0000 || if_id_o.valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midreset_restart: got valid=%b addr=%h ifid_valid=%b expected 1 80000000 0",
               imem_valid_o, imem_addr_o, if_id_o.valid);
    end
    step();
    step();
    @(negedge clk_i);
    checks++;
    if (if_id_o.valid !== 1'b1 || if_id_o.pc !== 32'h8000_0000 || if_id_o.instr !== instr_of(32'h8000_0000)) begin
      errors++;
      $display("[TB] FAIL midreset_decode: got valid=%b pc=%h instr=%h expected 1 80000000 %h",
               if_id_o.valid, if_id_o.pc, if_id_o.instr, instr_of(32'h8000_0000));
    end
  endtask

  initial begin
    rst_i        = 1'b1;
    resp_en      = 1'b0;
    imem_ready_i = 1'b0;
    stall_i      = 1'b0;
    ex_if_i      = '0;
    n_issued     = 0;
    test_reset();
    test_stream();
    test_stall();
    test_jump();
    test_jump_resp();
    test_ready_low();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
